// File: rtl/sdram_pkg.sv
// sdram_pkg
// Shared definitions for the SDRAM initialisation generator:
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - mode-register field positions and a helper that builds the mode word
//   - FSM state typedef used by sdram_init_gen
// No ports (package).
package sdram_pkg;

   localparam logic [3:0] CMD_NOP     = 4'b0111;
   localparam logic [3:0] CMD_PRECHAR = 4'b0010;
   localparam logic [3:0] CMD_AREF    = 4'b0001;
   localparam logic [3:0] CMD_MRSET   = 4'b0000;

   // A10 high during PRECHARGE selects all banks.
   localparam int unsigned A10_BIT = 10;

   // Mode register field positions.
   localparam int unsigned MR_BL_LSB = 0;
   localparam int unsigned MR_BT_BIT = 3;
   localparam int unsigned MR_CL_LSB = 4;
   localparam int unsigned MR_OP_LSB = 7;
   localparam int unsigned MR_WB_BIT = 9;

   typedef enum logic [2:0] {
      PWRUP,
      PRECH,
      WAIT_TRP,
      AREF,
      WAIT_TRFC,
      MRS,
      WAIT_TMRD,
      DONE
   } init_state_t;

   // Mode word: WB=0 (burst write), OP=00 (standard), BT=0 (sequential).
   function automatic logic [10:0] mode_word(input logic [2:0] cl, input logic [2:0] bl);
      logic [10:0] w;
      w                    = '0;
      w[MR_BL_LSB +: 3]    = bl;
      w[MR_BT_BIT]         = 1'b0;
      w[MR_CL_LSB +: 3]    = cl;
      w[MR_OP_LSB +: 2]    = 2'b00;
      w[MR_WB_BIT]         = 1'b0;
      return w;
   endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// sdram_wait_cnt
// Loadable down-counter used for all command-to-command spacing waits.
// Loading takes priority; otherwise the count decrements and saturates at 0.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset (count cleared)
//   load     - load load_val this cycle
//   load_val - value to load
//   zero     - count is 0
module sdram_wait_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_init_gen.sv
// sdram_init_gen
// SDRAM power-up initialisation sequencer: NOP for CLK_MHZ*PWRUP_US cycles,
// PRECHARGE-all, AREF_NUM auto-refreshes, MODE REGISTER SET, then done.
// Outputs are registered from the current state, so each command appears one
// cycle after its FSM state is entered.
// Optional feature: define SDRAM_INIT_REINIT_EN to add reinit_req, which
// restarts the sequence at PRECH (no power-up delay) when pulsed in DONE.
// Ports:
//   s_clk         - clock
//   s_rst         - synchronous active-high reset
//   reinit_req    - (SDRAM_INIT_REINIT_EN only) re-run the sequence from DONE
//   cmd           - SDRAM command {cs_n, ras_n, cas_n, we_n}
//   sdram_addr    - SDRAM address bus
//   bank_addr     - bank address (always 0)
//   flag_init_end - sticky initialisation-complete flag
//   init_busy     - sequence running (after power-up delay, before done)
module sdram_init_gen
   import sdram_pkg::*;
#(
   parameter int unsigned CLK_MHZ  = 50,
   parameter int unsigned PWRUP_US = 200,
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned BA_W     = 2,
   parameter int unsigned TRP_CYC  = 2,
   parameter int unsigned TRFC_CYC = 7,
   parameter int unsigned TMRD_CYC = 2,
   parameter int unsigned AREF_NUM = 2,
   parameter int unsigned MODE_CL  = 3,
   parameter logic [2:0]  MODE_BL  = 3'b010
) (
   input  logic              s_clk,
   input  logic              s_rst,
`ifdef SDRAM_INIT_REINIT_EN
   input  logic              reinit_req,
`endif
   output logic [3:0]        cmd,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [BA_W-1:0]   bank_addr,
   output logic              flag_init_end,
   output logic              init_busy
);

   localparam int unsigned PWRUP_CYC = CLK_MHZ * PWRUP_US;
   localparam int unsigned PWR_W     = $clog2(PWRUP_CYC + 1);

   localparam int unsigned WAIT_MAX_A = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
   localparam int unsigned WAIT_MAX   = (WAIT_MAX_A > TMRD_CYC) ? WAIT_MAX_A : TMRD_CYC;
   localparam int unsigned WAIT_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   init_state_t       state, state_d;
   logic [PWR_W-1:0]  pwr_cnt;
   logic [3:0]        aref_cnt;
   logic              wait_load;
   logic [WAIT_W-1:0] wait_val;
   logic              wait_zero;
   logic              reinit_fire;
   logic [3:0]        cmd_d;
   logic [ADDR_W-1:0] addr_d;
   logic              flag_d;
   logic              busy_d;

`ifdef SDRAM_INIT_REINIT_EN
   assign reinit_fire = reinit_req && (state == DONE);
`else
   assign reinit_fire = 1'b0;
`endif

   sdram_wait_cnt #(
      .W (WAIT_W)
   ) u_wait_cnt (
      .clk      (s_clk),
      .rst      (s_rst),
      .load     (wait_load),
      .load_val (wait_val),
      .zero     (wait_zero)
   );

   always_comb begin
      state_d   = state;
      wait_load = 1'b0;
      wait_val  = '0;
      cmd_d     = CMD_NOP;
      addr_d    = '0;
      flag_d    = 1'b0;
      busy_d    = 1'b1;

      unique case (state)
         // Leave one cycle early: the PRECHAR output lags the PRECH state by one.
         PWRUP:               if (pwr_cnt == PWR_W'(PWRUP_CYC - 1)) state_d = PRECH;
         PRECH, WAIT_TRP:     state_d = wait_zero ? AREF : WAIT_TRP;
         AREF, WAIT_TRFC: begin
            if (!wait_zero)                        state_d = WAIT_TRFC;
            else if (aref_cnt == 4'(AREF_NUM))     state_d = MRS;
            else                                   state_d = AREF;
         end
         MRS, WAIT_TMRD:      state_d = wait_zero ? DONE : WAIT_TMRD;
         DONE:                if (reinit_fire) state_d = PRECH;
         default:             state_d = PWRUP;
      endcase

      // Spacing is counted from the edge the command state is entered.
      unique case (state_d)
         PRECH: begin
            wait_load = 1'b1;
            wait_val  = WAIT_W'(TRP_CYC - 1);
         end
         AREF: begin
            wait_load = 1'b1;
            wait_val  = WAIT_W'(TRFC_CYC - 1);
         end
         MRS: begin
            wait_load = 1'b1;
            wait_val  = WAIT_W'(TMRD_CYC - 1);
         end
         default: ;
      endcase

      unique case (state)
         PRECH: begin
            cmd_d           = CMD_PRECHAR;
            addr_d[A10_BIT] = 1'b1;
         end
         AREF:  cmd_d = CMD_AREF;
         MRS: begin
            cmd_d  = CMD_MRSET;
            addr_d = ADDR_W'(mode_word(3'(MODE_CL), MODE_BL));
         end
         default: ;
      endcase

      // A reinit request clears the flag on the same edge it is accepted.
      flag_d = (state == DONE) && !reinit_fire;
      busy_d = (state != PWRUP) && (state != DONE);
   end

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state         <= PWRUP;
         pwr_cnt       <= '0;
         aref_cnt      <= '0;
         cmd           <= CMD_NOP;
         sdram_addr    <= '0;
         bank_addr     <= '0;
         flag_init_end <= 1'b0;
         init_busy     <= 1'b0;
      end else begin
         state         <= state_d;
         cmd           <= cmd_d;
         sdram_addr    <= addr_d;
         bank_addr     <= '0;
         flag_init_end <= flag_d;
         init_busy     <= busy_d;
         if (state == PWRUP) pwr_cnt <= pwr_cnt + 1'b1;
         if (state_d == PRECH)     aref_cnt <= '0;
         else if (state_d == AREF) aref_cnt <= aref_cnt + 1'b1;
      end
   end

endmodule

// File: doc/sdram_init_gen.md
SDRAM_INIT_GEN -- requirements
Module: sdram_init_gen

Interface
REQ-001 SHALL provide parameter CLK_MHZ, default 50, system clock frequency in MHz.
REQ-002 SHALL provide parameter PWRUP_US, default 200, power-up NOP delay in microseconds.
REQ-003 SHALL provide parameter ADDR_W, default 12, SDRAM address width (at least 11).
REQ-004 SHALL provide parameter BA_W, default 2, bank address width.
REQ-005 SHALL provide parameter TRP_CYC, default 2, precharge-to-next-command spacing in cycles (at least 1).
REQ-006 SHALL provide parameter TRFC_CYC, default 7, auto-refresh-to-next-command spacing in cycles (at least 1).
REQ-007 SHALL provide parameter TMRD_CYC, default 2, mode-register-set-to-done spacing in cycles (at least 1).
REQ-008 SHALL provide parameter AREF_NUM, default 2, number of auto-refresh commands (1..15).
REQ-009 SHALL provide parameter MODE_CL, default 3, CAS latency field (2 or 3).
REQ-010 SHALL provide parameter MODE_BL, default 3'b010, burst-length code (burst of 4), with sequential burst type.
REQ-011 SHALL have port s_clk, input, 1 bit, the only clock.
REQ-012 SHALL have port s_rst, input, 1 bit, synchronous active-high reset.
REQ-013 SHALL have port cmd, output, 4 bits, SDRAM command {cs_n, ras_n, cas_n, we_n}.
REQ-014 SHALL have port sdram_addr, output, ADDR_W bits, SDRAM address bus.
REQ-015 SHALL have port bank_addr, output, BA_W bits, bank address.
REQ-016 SHALL have port flag_init_end, output, 1 bit, sticky initialisation-complete flag.
REQ-017 SHALL have port init_busy, output, 1 bit, high while the sequence is running (after power-up delay, before done).

Function
REQ-018 SHALL register all outputs; command encodings: NOP 4'b0111, PRECHAR 4'b0010, AREF 4'b0001, MRSET 4'b0000.
REQ-019 SHALL use FSM states PWRUP, PRECH, WAIT_TRP, AREF, WAIT_TRFC, MRS, WAIT_TMRD, DONE.
REQ-020 SHALL output NOP for exactly CLK_MHZ*PWRUP_US cycles after reset release; counter width SHALL be derived by $clog2.
REQ-021 SHALL drive PRECHAR for one cycle on cycle index CLK_MHZ*PWRUP_US, where index 0 is the first cycle after reset release, with sdram_addr[10]=1 and all other address bits 0.
REQ-022 SHALL issue the first AREF exactly TRP_CYC cycles after PRECHAR.
REQ-023 SHALL issue successive AREFs TRFC_CYC cycles apart, AREF_NUM in total.
REQ-024 SHALL issue MRSET TRFC_CYC cycles after the last AREF, with sdram_addr = {zeros, WB=0, OP=2'b00, CL[2:0], BT=0, BL[2:0]}; defaults give 12'h032.
REQ-025 SHALL assert flag_init_end TMRD_CYC cycles after MRSET and hold it high until reset.
REQ-026 SHALL output NOP in every cycle that carries no listed command, including all of DONE.
REQ-027 SHALL hold sdram_addr at 0 on all non-PRECHAR, non-MRSET cycles.
REQ-028 SHALL hold bank_addr at 0 at all times.
REQ-029 SHALL keep init_busy and flag_init_end mutually exclusive.

Reset
REQ-030 SHALL, on s_rst high at any clock edge (including mid-sequence), set on the next edge: cmd=NOP, sdram_addr=0, flag_init_end=0, init_busy=0, state=PWRUP, all counters 0.
REQ-031 SHALL restart the full power-up delay after every reset release.

Configuration
REQ-032 SHALL, with SDRAM_INIT_REINIT_EN defined, add input reinit_req (1 bit); a one-cycle pulse while in DONE clears flag_init_end on the next edge and restarts at PRECH (no power-up delay).
REQ-033 SHALL ignore reinit_req in any state other than DONE.
REQ-034 SHALL, without SDRAM_INIT_REINIT_EN, omit the reinit_req port; DONE is terminal until reset.

Structure
REQ-035 SHALL place command encodings, mode-register field positions and the FSM state typedef in shared package sdram_pkg.
REQ-036 SHALL implement the spacing waits with one reusable loadable down-counter sub-module, sdram_wait_cnt.

Verification
REQ-037 Defaults, reset released at cycle 0 -> PRECHAR with addr 12'h400 at cycle 10000; AREF at 10002 and 10009; MRSET with addr 12'h032 at 10016; flag_init_end rises at 10018.
REQ-038 CLK_MHZ=1, PWRUP_US=10, AREF_NUM=8, TRFC_CYC=3 -> PRECHAR at 10; 8 AREFs at 12,15,...,33; MRSET at 36; done at 38.
REQ-039 s_rst pulsed at cycle 10005 (between AREFs) -> cmd=NOP and init_busy=0 next edge; PRECHAR recurs 10000 cycles after release.
REQ-040 MODE_CL=2, MODE_BL=3'b011 -> MRSET address 12'h023.
REQ-041 With SDRAM_INIT_REINIT_EN, reinit_req pulsed 5 cycles after done -> flag_init_end low next cycle; PRECHAR 1 cycle later; flag re-asserts 18 cycles after PRECHAR. A pulse mid-sequence has no effect.
